// File: rtl/viterbi_ber_monitor.sv
// -----------------------------------------------------------------------------
// viterbi_ber_monitor
//
// Bit-error-rate monitor placed directly after a Viterbi decoder. The
// transmitted reference bits (encoder input) are buffered in a small FIFO; the
// decoded stream is compared bit by bit against the FIFO head.
//
// In SEARCH the monitor slips the decoded stream against the reference (a
// mismatch holds the FIFO head) until SYNC_LEN consecutive matches are seen.
// In LOCKED every compare pops the FIFO and is counted as good or bad. Lock is
// dropped when LOSS_THR mismatches fall into one WIN-compare window.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   clear_i      synchronous clear, same effect as reset, highest priority
//   ref_valid_i  push qualifier for ref_bit_i
//   ref_bit_i    transmitted reference bit
//   dec_valid_i  compare qualifier for dec_bit_i
//   dec_bit_i    decoder output bit
//   good_ct_o    matched bits while locked (saturating)
//   bad_ct_o     mismatched bits while locked (saturating)
//   slip_ct_o    slips taken while searching (saturating at 255)
//   locked_o     alignment acquired
//   ovf_o        sticky: reference push dropped because the FIFO was full
//   unf_o        sticky: decoded bit arrived while the FIFO was empty
// -----------------------------------------------------------------------------
module viterbi_ber_monitor #(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16,
  parameter int SYNC_LEN   = 8,
  parameter int WIN        = 32,
  parameter int LOSS_THR   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             ref_valid_i,
  input  logic             ref_bit_i,
  input  logic             dec_valid_i,
  input  logic             dec_bit_i,
  output logic [CNT_W-1:0] good_ct_o,
  output logic [CNT_W-1:0] bad_ct_o,
  output logic [7:0]       slip_ct_o,
  output logic             locked_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RUN_W = $clog2(SYNC_LEN + 1);
  localparam int WC_W  = $clog2(WIN + 1);
  localparam int WE_W  = $clog2(LOSS_THR + 1);

  localparam logic [AW:0]      FULL_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0] SYNC_C = RUN_W'(SYNC_LEN);
  localparam logic [WC_W-1:0]  WIN_C  = WC_W'(WIN);
  localparam logic [WE_W-1:0]  LOSS_C = WE_W'(LOSS_THR);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_slip(input logic [7:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Reference FIFO storage (data only, never reset)
  logic          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [WC_W-1:0]  wc_q, wc_d, wc_inc;
  logic [WE_W-1:0]  we_q, we_d, we_inc;
  logic [CNT_W-1:0] good_d, bad_d;
  logic [7:0]       slip_d;

  logic empty, full, head;
  logic cmp_vld_p0, match_p0, pop_p0, push_ok_p0, ovf_set_p0, unf_set_p0;

  // ---- Stage p0: combinational compare against the FIFO head ----
  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_C);
  assign head       = mem[rd_ptr_q];
  assign cmp_vld_p0 = dec_valid_i && !empty;
  assign match_p0   = (dec_bit_i == head);
  // A push into a full FIFO still fits when the same cycle pops.
  assign push_ok_p0 = ref_valid_i && (!full || pop_p0);
  assign ovf_set_p0 = ref_valid_i && full && !pop_p0;
  assign unf_set_p0 = dec_valid_i && empty;

  assign run_inc = run_q + 1'b1;
  assign wc_inc  = wc_q + 1'b1;
  assign we_inc  = we_q + 1'b1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    wc_d    = wc_q;
    we_d    = we_q;
    good_d  = good_ct_o;
    bad_d   = bad_ct_o;
    slip_d  = slip_ct_o;
    pop_p0  = 1'b0;
    if (cmp_vld_p0) begin
      if (state_q == SEARCH) begin
        if (match_p0) begin
          pop_p0 = 1'b1;
          if (run_inc == SYNC_C) begin
            state_d = LOCKED;
            run_d   = '0;
            wc_d    = '0;
            we_d    = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          // Slip: hold the head so the decoded stream shifts by one bit.
          run_d  = '0;
          slip_d = sat_inc_slip(slip_ct_o);
        end
      end else begin
        pop_p0 = 1'b1;
        if (match_p0) good_d = sat_inc_cnt(good_ct_o);
        else          bad_d  = sat_inc_cnt(bad_ct_o);
        // Loss of lock wins over the window boundary in the same cycle.
        if (!match_p0 && (we_inc == LOSS_C)) begin
          state_d = SEARCH;
          run_d   = '0;
          wc_d    = '0;
          we_d    = '0;
        end else if (wc_inc == WIN_C) begin
          wc_d = '0;
          we_d = '0;
        end else begin
          wc_d = wc_inc;
          if (!match_p0) we_d = we_inc;
        end
      end
    end
  end

  // ---- Stage p1: registered state, counters and flags ----
  always_ff @(posedge clk) begin
    if (push_ok_p0 && !clear_i) mem[wr_ptr_q] <= ref_bit_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= SEARCH;
      run_q     <= '0;
      wc_q      <= '0;
      we_q      <= '0;
      good_ct_o <= '0;
      bad_ct_o  <= '0;
      slip_ct_o <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      state_q   <= SEARCH;
      run_q     <= '0;
      wc_q      <= '0;
      we_q      <= '0;
      good_ct_o <= '0;
      bad_ct_o  <= '0;
      slip_ct_o <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else begin
      if (push_ok_p0) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_p0)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok_p0, pop_p0})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      state_q   <= state_d;
      run_q     <= run_d;
      wc_q      <= wc_d;
      we_q      <= we_d;
      good_ct_o <= good_d;
      bad_ct_o  <= bad_d;
      slip_ct_o <= slip_d;
      ovf_o     <= ovf_o | ovf_set_p0;
      unf_o     <= unf_o | unf_set_p0;
    end
  end

  assign locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// -----------------------------------------------------------------------------
// tb_viterbi_ber_monitor
//
// Bench for viterbi_ber_monitor. A main instance (CNT_W=16) and a narrow
// instance (CNT_W=4) share all inputs so saturation of the good/bad counters
// can be reached in a few cycles. A reference model built on a queue of
// pending reference bits tracks the expected outputs cycle by cycle.
// -----------------------------------------------------------------------------
module tb_viterbi_ber_monitor;

  localparam int DEPTH = 64;
  localparam int SYNC  = 8;
  localparam int WIN   = 32;
  localparam int LOSS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0, rv = 1'b0, rb = 1'b0, dv = 1'b0, db = 1'b0;

  logic [15:0] good_ct, bad_ct;
  logic [7:0]  slip_ct;
  logic        locked, ovf, unf;
  logic [3:0]  s_good, s_bad;
  logic [7:0]  s_slip;
  logic        s_locked, s_ovf, s_unf;

  int pass_ct = 0;
  int tot_ct  = 0;

  // Reference model state
  bit mq[$];
  int m_good, m_bad, m_slip, m_run, m_wc, m_we;
  bit m_locked, m_ovf, m_unf;

  bit rbits[1024];

  always #5 clk = ~clk;

  viterbi_ber_monitor #(.FIFO_DEPTH(DEPTH), .CNT_W(16), .SYNC_LEN(SYNC),
                        .WIN(WIN), .LOSS_THR(LOSS)) dut (
    .clk(clk), .rst(rst), .clear_i(clear), .ref_valid_i(rv), .ref_bit_i(rb),
    .dec_valid_i(dv), .dec_bit_i(db), .good_ct_o(good_ct), .bad_ct_o(bad_ct),
    .slip_ct_o(slip_ct), .locked_o(locked), .ovf_o(ovf), .unf_o(unf));

  viterbi_ber_monitor #(.FIFO_DEPTH(DEPTH), .CNT_W(4), .SYNC_LEN(SYNC),
                        .WIN(WIN), .LOSS_THR(LOSS)) dut_sat (
    .clk(clk), .rst(rst), .clear_i(clear), .ref_valid_i(rv), .ref_bit_i(rb),
    .dec_valid_i(dv), .dec_bit_i(db), .good_ct_o(s_good), .bad_ct_o(s_bad),
    .slip_ct_o(s_slip), .locked_o(s_locked), .ovf_o(s_ovf), .unf_o(s_unf));

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_good = 0; m_bad = 0; m_slip = 0; m_run = 0; m_wc = 0; m_we = 0;
    m_locked = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One clock of the monitor's rules, evaluated on the pre-edge state.
  task automatic model_step(input bit c, input bit v, input bit b, input bit d, input bit e);
    bit pop, match, was_full;
    pop = 0;
    if (c) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (d && mq.size() == 0) m_unf = 1;
    if (d && mq.size() > 0) begin
      match = (e == mq[0]);
      if (!m_locked) begin
        if (match) begin
          pop = 1;
          m_run++;
          if (m_run == SYNC) begin
            m_locked = 1; m_run = 0; m_wc = 0; m_we = 0;
          end
        end else begin
          m_run = 0;
          m_slip = clampv(m_slip + 1, 255);
        end
      end else begin
        pop = 1;
        m_wc++;
        if (match) m_good++;
        else begin m_bad++; m_we++; end
        if (!match && m_we == LOSS) begin
          m_locked = 0; m_run = 0; m_wc = 0; m_we = 0;
        end else if (m_wc == WIN) begin
          m_wc = 0; m_we = 0;
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (v) begin
      if (!was_full || pop) mq.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic cyc(input bit c, input bit v, input bit b, input bit d, input bit e);
    clear = c; rv = v; rb = b; dv = d; db = e;
    model_step(c, v, b, d, e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tot_ct++;
    if ({good_ct, bad_ct, slip_ct, locked, ovf, unf} !== 43'd0)
      $display("FAIL reset_state got=%h exp=0", {good_ct, bad_ct, slip_ct, locked, ovf, unf});
    else pass_ct++;
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_clean();
    int di, k;
    cyc(1, 0, 0, 0, 0);
    di = 0; k = 0;
    for (int t = 0; di < 300; t++) begin
      bit d;
      d = (t >= 12);
      cyc(0, t < 300, rbits[t], d, rbits[di]);
      if (d) begin
        di++;
        if (di == 7) begin
          tot_ct++;
          if (locked !== 1'b0) $display("FAIL clean_lock_early got=%b exp=0", locked); else pass_ct++;
        end
        if (di == 8) begin
          tot_ct++;
          if (locked !== 1'b1) $display("FAIL clean_lock_8th got=%b exp=1", locked); else pass_ct++;
        end
      end
    end
    tot_ct++;
    if (good_ct !== 16'd292 || good_ct !== 16'(m_good))
      $display("FAIL clean_good got=%0d exp=292 model=%0d", good_ct, m_good); else pass_ct++;
    tot_ct++;
    if ({bad_ct, slip_ct, ovf, unf} !== 26'd0)
      $display("FAIL clean_bad_slip_flags got=%h exp=0", {bad_ct, slip_ct, ovf, unf}); else pass_ct++;
  endtask

  task automatic test_garbage();
    int di;
    cyc(1, 0, 0, 0, 0);
    di = 0;
    for (int t = 0; di < 200; t++) begin
      if (t < 5)       cyc(0, 1, rbits[t], 0, 0);
      else if (t < 8)  cyc(0, 1, rbits[t], 1, ~rbits[0]);
      else begin
        cyc(0, t < 200, rbits[t], 1, rbits[di]);
        di++;
      end
      if (t == 7) begin
        tot_ct++;
        if (slip_ct !== 8'd3 || locked !== 1'b0)
          $display("FAIL garbage_slip got=%0d/%b exp=3/0", slip_ct, locked); else pass_ct++;
      end
      if (di == 8 && t == 15) begin
        tot_ct++;
        if (locked !== 1'b1) $display("FAIL garbage_lock got=%b exp=1", locked); else pass_ct++;
      end
    end
    tot_ct++;
    if (slip_ct !== 8'd3 || bad_ct !== 16'd0 || good_ct !== 16'd192 || good_ct !== 16'(m_good))
      $display("FAIL garbage_final got=slip%0d bad%0d good%0d exp=3/0/192", slip_ct, bad_ct, good_ct);
    else pass_ct++;
  endtask

  task automatic test_errors();
    int di, unlocked;
    cyc(1, 0, 0, 0, 0);
    di = 0; unlocked = 0;
    for (int t = 0; di < 264; t++) begin
      bit d, err;
      d = (t >= 4);
      err = (di >= 8) && (((di - 8) % 16 == 8) || ((di - 8) % 16 == 9));
      cyc(0, t < 264, rbits[t], d, rbits[di] ^ err);
      if (d) begin
        di++;
        if (di >= 8 && locked !== 1'b1) unlocked++;
      end
    end
    tot_ct++;
    if (good_ct !== 16'd224 || bad_ct !== 16'd32)
      $display("FAIL errors_counts got=%0d/%0d exp=224/32", good_ct, bad_ct); else pass_ct++;
    tot_ct++;
    if (unlocked !== 0) $display("FAIL errors_lock_held got=%0d unlocked cycles exp=0", unlocked);
    else pass_ct++;
  endtask

  task automatic test_burst();
    int di;
    cyc(1, 0, 0, 0, 0);
    di = 0;
    for (int t = 0; di < 60; t++) begin
      bit d, err;
      d = (t >= 4);
      err = (di >= 24) && (di < 32);
      cyc(0, t < 60, rbits[t], d, rbits[di] ^ err);
      if (d) begin
        if (di == 30 || di == 31 || di == 38 || di == 39) begin
          tot_ct++;
          if (locked !== ((di == 30 || di == 39) ? 1'b1 : 1'b0))
            $display("FAIL burst_lock_at_%0d got=%b exp=%b", di, locked, (di == 30 || di == 39));
          else pass_ct++;
        end
        di++;
      end
    end
    tot_ct++;
    if (bad_ct !== 16'd8 || good_ct !== 16'd36 || good_ct !== 16'(m_good) || locked !== 1'b1)
      $display("FAIL burst_final got=bad%0d good%0d lk%b exp=8/36/1", bad_ct, good_ct, locked);
    else pass_ct++;
  endtask

  task automatic test_ovf_unf();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    tot_ct++;
    if (unf !== 1'b1 || {good_ct, bad_ct, slip_ct, locked} !== 41'd0)
      $display("FAIL unf_empty got=unf%b rest=%h exp=1/0", unf, {good_ct, bad_ct, slip_ct, locked});
    else pass_ct++;
    cyc(1, 0, 0, 0, 0);
    for (int t = 0; t < 65; t++) begin
      cyc(0, 1, rbits[t], 0, 0);
      if (t == 63) begin
        tot_ct++;
        if (ovf !== 1'b0) $display("FAIL ovf_early got=%b exp=0", ovf); else pass_ct++;
      end
    end
    tot_ct++;
    if (ovf !== 1'b1 || ovf !== m_ovf) $display("FAIL ovf_set got=%b exp=1", ovf); else pass_ct++;
    // Full FIFO plus a same-cycle pop: the extra push must be kept.
    cyc(0, 1, ~rbits[64], 1, rbits[0]);
    for (int i = 1; i < 64; i++) cyc(0, 0, 0, 1, rbits[i]);
    cyc(0, 0, 0, 1, ~rbits[64]);
    tot_ct++;
    if (unf !== 1'b0 || good_ct !== 16'd57 || locked !== 1'b1)
      $display("FAIL full_push_pop got=unf%b good%0d lk%b exp=0/57/1", unf, good_ct, locked);
    else pass_ct++;
    cyc(0, 0, 0, 1, 1);
    tot_ct++;
    if (unf !== 1'b1 || good_ct !== 16'd57 || bad_ct !== 16'd0)
      $display("FAIL unf_drain got=unf%b good%0d bad%0d exp=1/57/0", unf, good_ct, bad_ct);
    else pass_ct++;
  endtask

  task automatic test_saturation();
    int di;
    cyc(1, 0, 0, 0, 0);
    di = 0;
    for (int t = 0; di < 104; t++) begin
      bit d, err;
      d = (t >= 4);
      err = (di >= 8) && ((di - 8) % 4 == 3) && ((di - 8) % 32 < 28);
      cyc(0, t < 104, rbits[t], d, rbits[di] ^ err);
      if (d) di++;
    end
    tot_ct++;
    if (s_good !== 4'hF || s_bad !== 4'hF || s_locked !== 1'b1)
      $display("FAIL sat_narrow got=%h/%h/%b exp=f/f/1", s_good, s_bad, s_locked); else pass_ct++;
    tot_ct++;
    if (good_ct !== 16'd75 || bad_ct !== 16'd21)
      $display("FAIL sat_wide got=%0d/%0d exp=75/21", good_ct, bad_ct); else pass_ct++;
  endtask

  task automatic test_async_reset();
    cyc(1, 0, 0, 0, 0);
    for (int t = 0; t < 30; t++) cyc(0, 1, rbits[t], t >= 3, rbits[(t >= 3) ? t - 3 : 0]);
    cyc(0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    model_reset();
    #1;
    tot_ct++;
    if ({good_ct, bad_ct, slip_ct, locked, ovf, unf} !== 43'd0)
      $display("FAIL async_reset got=%h exp=0", {good_ct, bad_ct, slip_ct, locked, ovf, unf});
    else pass_ct++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_clear();
    int di;
    for (int t = 0; t < 30; t++) cyc(0, 1, rbits[t], t >= 3, rbits[(t >= 3) ? t - 3 : 0]);
    tot_ct++;
    if (locked !== 1'b1 || good_ct !== 16'(m_good))
      $display("FAIL preclear got=lk%b good%0d exp=1/%0d", locked, good_ct, m_good); else pass_ct++;
    cyc(1, 1, 1, 1, 1);
    tot_ct++;
    if ({good_ct, bad_ct, slip_ct, locked, ovf, unf} !== 43'd0)
      $display("FAIL clear_state got=%h exp=0", {good_ct, bad_ct, slip_ct, locked, ovf, unf});
    else pass_ct++;
    di = 0;
    for (int t = 0; di < 50; t++) begin
      cyc(0, t < 50, rbits[t + 100], t >= 3, rbits[di + 100]);
      if (t >= 3) di++;
    end
    tot_ct++;
    if (good_ct !== 16'd42 || locked !== 1'b1 || bad_ct !== 16'd0)
      $display("FAIL clear_relock got=good%0d lk%b bad%0d exp=42/1/0", good_ct, locked, bad_ct);
    else pass_ct++;
  endtask

  task automatic test_random();
    int burst;
    cyc(1, 0, 0, 0, 0);
    burst = 0;
    for (int t = 0; t < 1500; t++) begin
      bit c, v, b, d, e, err;
      c = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1);
      d = ($urandom_range(0, 9) < 7);
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(4, 12);
      err = (burst > 0) || ($urandom_range(0, 19) == 0);
      if (burst > 0 && d) burst--;
      e = (mq.size() > 0) ? (mq[0] ^ err) : b;
      cyc(c, v, b, d, e);
      tot_ct++;
      if ({good_ct, bad_ct, slip_ct, locked, ovf, unf} !==
          {16'(clampv(m_good, 65535)), 16'(clampv(m_bad, 65535)), 8'(m_slip), m_locked, m_ovf, m_unf} ||
          {s_good, s_bad} !== {4'(clampv(m_good, 15)), 4'(clampv(m_bad, 15))})
        $display("FAIL random_cyc%0d got=%0d/%0d/%0d/%b/%b/%b exp=%0d/%0d/%0d/%b/%b/%b", t,
                 good_ct, bad_ct, slip_ct, locked, ovf, unf,
                 m_good, m_bad, m_slip, m_locked, m_ovf, m_unf);
      else pass_ct++;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rbits[i] = $urandom_range(0, 1);
    model_reset();
    test_reset();
    test_clean();
    test_garbage();
    test_errors();
    test_burst();
    test_ovf_unf();
    test_saturation();
    test_async_reset();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", pass_ct, tot_ct);
    $finish;
  end

endmodule
